ir_regfile_alu_datapath: RTL and testbench



---
 rtl/ir_regfile_alu_datapath.sv | 177 +++++++++++++++++
 tb/tb_ir_regfile_alu_datapath.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ir_regfile_alu_datapath.sv
// ir_regfile_alu_datapath
// Multicycle-CPU datapath slice: instruction register, destination-select
// mux, 32x32 register file (r0 hardwired to zero), A/B operand latches,
// ALU source muxes, sign extender and a combinational 32-bit ALU.
// Optional build macro IRALU_FLAGS_EN adds carryout/overflow outputs.
module ir_regfile_alu_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        ir_we,
  input  logic [31:0] Dw,
  input  logic        WrEn,
  input  logic [1:0]  control_signalDST,
  input  logic        control_signalALUa,
  input  logic [1:0]  control_signalALUb,
  input  logic [2:0]  command,
  input  logic [31:0] pc_in,
  output logic [31:0] ALU_out,
  output logic        zero
`ifdef IRALU_FLAGS_EN
  ,
  output logic        carryout,
  output logic        overflow
`endif
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  logic [31:0] r_ir;
  logic [31:0] r_regs [32];
  logic [31:0] r_a;
  logic [31:0] r_b;

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm16;
  logic [31:0] w_imm_ext;
  logic [4:0]  w_dst;
  logic [31:0] w_da;
  logic [31:0] w_db;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_result;

  // Instruction register: loads only when ir_we is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir <= 32'd0;
    end else if (ir_we) begin
      r_ir <= instr_in;
    end else begin
      r_ir <= r_ir;
    end
  end

  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_imm16   = r_ir[15:0];
  assign w_imm_ext = {{16{w_imm16[15]}}, w_imm16};

  // Destination select: Rd, Rt, link register 31, Rd.
  always_comb begin
    w_dst = w_rd;
    case (control_signalDST)
      2'b00:   w_dst = w_rd;
      2'b01:   w_dst = w_rt;
      2'b10:   w_dst = 5'd31;
      2'b11:   w_dst = w_rd;
      default: w_dst = w_rd;
    endcase
  end

  // Register file write port; r0 is never written so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (WrEn && (w_dst != 5'd0)) begin
      r_regs[w_dst] <= Dw;
    end else begin
      r_regs[0] <= 32'd0;
    end
  end

  // Read ports show the pre-write contents during a write cycle (no bypass).
  assign w_da = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_db = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

  // Operand latches capture the read ports on every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= 32'd0;
      r_b <= 32'd0;
    end else begin
      r_a <= w_da;
      r_b <= w_db;
    end
  end

  assign w_alu_a = control_signalALUa ? r_a : pc_in;

  // ALU B source: immediate, latch B, PC increment, or zero.
  always_comb begin
    w_alu_b = 32'd0;
    case (control_signalALUb)
      2'b00:   w_alu_b = w_imm_ext;
      2'b01:   w_alu_b = r_b;
      2'b10:   w_alu_b = 32'd4;
      2'b11:   w_alu_b = 32'd0;
      default: w_alu_b = 32'd0;
    endcase
  end

  assign w_sum  = w_alu_a + w_alu_b;
  assign w_diff = w_alu_a - w_alu_b;

  // ALU operation select; all arithmetic wraps modulo 2^32.
  always_comb begin
    w_result = 32'd0;
    case (command)
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_diff;
      OP_XOR:  w_result = w_alu_a ^ w_alu_b;
      OP_SLT:  w_result = ($signed(w_alu_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
      OP_AND:  w_result = w_alu_a & w_alu_b;
      OP_NAND: w_result = ~(w_alu_a & w_alu_b);
      OP_NOR:  w_result = ~(w_alu_a | w_alu_b);
      OP_OR:   w_result = w_alu_a | w_alu_b;
      default: w_result = 32'd0;
    endcase
  end

  assign ALU_out = w_result;
  assign zero    = ~|w_result;

`ifdef IRALU_FLAGS_EN
  logic w_a31;
  logic w_b31;

  assign w_a31 = w_alu_a[31];
  assign w_b31 = w_alu_b[31];

  // Flags: the carry out of bit 31 is rebuilt from the operand MSBs and the
  // result MSB; for SUB the second operand is ~B so carry means no-borrow.
  always_comb begin
    carryout = 1'b0;
    overflow = 1'b0;
    case (command)
      OP_ADD: begin
        carryout = (w_a31 & w_b31) | ((w_a31 ^ w_b31) & ~w_sum[31]);
        overflow = (w_a31 == w_b31) && (w_sum[31] != w_a31);
      end
      OP_SUB: begin
        carryout = (w_a31 & ~w_b31) | ((w_a31 ^ ~w_b31) & ~w_diff[31]);
        overflow = (w_a31 != w_b31) && (w_diff[31] != w_a31);
      end
      default: begin
        carryout = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end
`endif

endmodule

// File: tb/tb_ir_regfile_alu_datapath.sv
// Directed self-checking bench for ir_regfile_alu_datapath.
module tb_ir_regfile_alu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        ir_we;
  logic [31:0] Dw;
  logic        WrEn;
  logic [1:0]  control_signalDST;
  logic        control_signalALUa;
  logic [1:0]  control_signalALUb;
  logic [2:0]  command;
  logic [31:0] pc_in;
  logic [31:0] ALU_out;
  logic        zero;
`ifdef IRALU_FLAGS_EN
  logic        carryout;
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  ir_regfile_alu_datapath dut (
    .clk                (clk),
    .reset              (reset),
    .instr_in           (instr_in),
    .ir_we              (ir_we),
    .Dw                 (Dw),
    .WrEn               (WrEn),
    .control_signalDST  (control_signalDST),
    .control_signalALUa (control_signalALUa),
    .control_signalALUb (control_signalALUb),
    .command            (command),
    .pc_in              (pc_in),
    .ALU_out            (ALU_out),
    .zero               (zero)
`ifdef IRALU_FLAGS_EN
    ,
    .carryout           (carryout),
    .overflow           (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
    enc = {6'd0, rs, rt, rd, 11'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] w);
    instr_in = w;
    ir_we    = 1'b1;
    tick();
    ir_we    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] dst, input logic [31:0] d);
    control_signalDST = dst;
    Dw   = d;
    WrEn = 1'b1;
    tick();
    WrEn = 1'b0;
  endtask

  // Set ALU controls and wait half a cycle for the combinational path.
  task automatic alu(input logic a_sel, input logic [1:0] b_sel, input logic [2:0] op);
    control_signalALUa = a_sel;
    control_signalALUb = b_sel;
    command            = op;
    @(negedge clk);
  endtask

  // Route register r through latch A (IR edge, latch edge) and check it.
  task automatic rd_rs(input string tag, input logic [4:0] r, input logic [31:0] exp);
    load_ir(enc(r, 5'd0, 5'd0));
    tick();
    alu(1'b1, 2'b11, 3'b000);
    chk(tag, ALU_out, exp);
  endtask

  initial begin
    reset = 1'b1; instr_in = 32'd0; ir_we = 1'b0; Dw = 32'd0; WrEn = 1'b0;
    control_signalDST = 2'b00; control_signalALUa = 1'b1; control_signalALUb = 2'b01;
    command = 3'b000; pc_in = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", ALU_out, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;

    // Write reg 3 via Rd, read back through latch A.
    load_ir(enc(5'd0, 5'd0, 5'd3));
    wr(2'b00, 32'h07C00000);
    rd_rs("wr_rd3", 5'd3, 32'h07C00000);
    chk("wr_rd3_zero", {31'd0, zero}, 32'd0);

    // r0 ignores writes; DST=10 targets r31.
    load_ir(enc(5'd0, 5'd0, 5'd0));
    wr(2'b00, 32'hFFFFFFFF);
    rd_rs("r0_read", 5'd0, 32'd0);
    wr(2'b10, 32'hFFFFFFFF);
    rd_rs("r31_link", 5'd31, 32'hFFFFFFFF);

    // No bypass: write r9 while Rs=9, latch sees old value first.
    load_ir(enc(5'd9, 5'd0, 5'd9));
    control_signalALUa = 1'b1; control_signalALUb = 2'b11; command = 3'b000;
    wr(2'b00, 32'h0000ABCD);
    chk("nobypass_old", ALU_out, 32'd0);
    tick();
    chk("nobypass_new", ALU_out, 32'h0000ABCD);

    // A=5 in r5 (via Rd), B=7 in r7 (via Rt).
    load_ir(enc(5'd0, 5'd0, 5'd5));
    wr(2'b00, 32'd5);
    load_ir(enc(5'd0, 5'd7, 5'd0));
    wr(2'b01, 32'd7);
    load_ir(enc(5'd5, 5'd7, 5'd0));
    tick();
    alu(1'b1, 2'b01, 3'b000); chk("add", ALU_out, 32'd12);
    alu(1'b1, 2'b01, 3'b001); chk("sub", ALU_out, 32'hFFFFFFFE);
    alu(1'b1, 2'b01, 3'b010); chk("xor", ALU_out, 32'd2);
    alu(1'b1, 2'b01, 3'b011); chk("slt", ALU_out, 32'd1);
    alu(1'b1, 2'b01, 3'b100); chk("and", ALU_out, 32'd5);
    alu(1'b1, 2'b01, 3'b101); chk("nand", ALU_out, 32'hFFFFFFFA);
    alu(1'b1, 2'b01, 3'b110); chk("nor", ALU_out, 32'hFFFFFFF8);
    alu(1'b1, 2'b01, 3'b111); chk("or", ALU_out, 32'd7);
    pc_in = 32'd7;
    alu(1'b0, 2'b01, 3'b001); chk("sub_eq", ALU_out, 32'd0);
    chk("sub_eq_zero", {31'd0, zero}, 32'd1);
    pc_in = 32'd8;
    alu(1'b0, 2'b01, 3'b011); chk("slt_false", ALU_out, 32'd0);
    pc_in = 32'h80000000;
    alu(1'b0, 2'b01, 3'b011); chk("slt_neg", ALU_out, 32'd1);

    // Immediate / PC paths.
    load_ir(32'h0000FFFF);
    pc_in = 32'h003E0000;
    alu(1'b0, 2'b00, 3'b000); chk("pc_imm_neg", ALU_out, 32'h003DFFFF);
    alu(1'b0, 2'b10, 3'b000); chk("pc_plus4", ALU_out, 32'h003E0004);
    load_ir(32'h00007FFF);
    pc_in = 32'd0;
    alu(1'b0, 2'b00, 3'b000); chk("imm_pos", ALU_out, 32'h00007FFF);

    // IR hold with ir_we low.
    instr_in = 32'hFFFF8000;
    tick();
    alu(1'b0, 2'b00, 3'b000); chk("ir_hold", ALU_out, 32'h00007FFF);

`ifdef IRALU_FLAGS_EN
    load_ir(32'h00000001);
    pc_in = 32'h7FFFFFFF;
    alu(1'b0, 2'b00, 3'b000);
    chk("ovf_add", {30'd0, carryout, overflow}, 32'd1);
    pc_in = 32'hFFFFFFFF;
    alu(1'b0, 2'b00, 3'b000);
    chk("carry_add", {30'd0, carryout, overflow}, 32'd2);
    pc_in = 32'h80000000;
    alu(1'b0, 2'b00, 3'b001);
    chk("ovf_sub", {30'd0, carryout, overflow}, 32'd3);
    alu(1'b0, 2'b00, 3'b111);
    chk("flags_or", {30'd0, carryout, overflow}, 32'd0);
`endif

    // Mid-run reset clears register file and latches.
    load_ir(enc(5'd0, 5'd0, 5'd5));
    wr(2'b00, 32'h00001234);
    rd_rs("pre_reset", 5'd5, 32'h00001234);
    reset = 1'b1;
    #1;
    chk("async_reset", ALU_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_rs("post_reset", 5'd5, 32'd0);
    chk("post_reset_zero", {31'd0, zero}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
